// File: rtl/cbus_mem_responder_pkg.sv
// Shared CBus types and the defaults for the memory responder.
// Burst length is encoded as (beats - 1); byte strobes select written lanes.
package cbus_mem_responder_pkg;

    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef logic [3:0]  strobe_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic    valid;
        logic    is_write;
        msize_t  size;
        word_t   addr;
        strobe_t strobe;
        word_t   data;
        mlen_t   len;
    } cbus_req_t;

    typedef struct packed {
        logic  ready;
        logic  last;
        word_t data;
    } cbus_resp_t;

    localparam int unsigned CBUS_MEM_DEFAULT_LATENCY = 2;
    localparam int unsigned CBUS_MEM_MAX_LATENCY     = 15;

endpackage

// File: rtl/cbus_mem_responder_if.sv
// CBus request/response bundle between an initiator and a responder.
interface cbus_mem_responder_if;

    cbus_mem_responder_pkg::cbus_req_t  creq;
    cbus_mem_responder_pkg::cbus_resp_t cresp;

    modport master (output creq, input  cresp);
    modport slave  (input  creq, output cresp);

endinterface

// File: rtl/cbus_word_ram.sv
// Single-port 32-bit word RAM, byte write-enable, asynchronous read.
module cbus_word_ram
    import cbus_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  strobe_t               we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  word_t                 wdata,
    output word_t                 rdata
);

    word_t mem [2**ADDR_WIDTH];

    assign rdata = mem[addr];

    // Contents are never reset; only enabled byte lanes change.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/cbus_mem_responder.sv
// CBus responder backed by an internal word RAM with programmable first-beat latency.
// Response outputs depend only on registered state and RAM contents.
module cbus_mem_responder
    import cbus_mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned LATENCY    = CBUS_MEM_DEFAULT_LATENCY
) (
    input  logic                 clk,
    input  logic                 reset,
    cbus_mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        TURN
    } state_t;

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t                state;
    state_t                state_next;
    logic [3:0]            wait_cnt;
    logic [3:0]            beat;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  is_write_q;
    mlen_t                 len_q;
    logic                  last_beat;
    strobe_t               ram_we;
    word_t                 ram_rdata;
    logic                  unused_req;

    assign last_beat  = (beat == len_q);
    assign unused_req = ^{bus.creq.size, bus.creq.addr[31:ADDR_WIDTH+2], bus.creq.addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.creq.valid) begin
                    state_next = (LAT == 4'd0) ? BURST : WAIT;
                end
            end
            WAIT: begin
                if (!bus.creq.valid) begin
                    state_next = IDLE;
                end else if (wait_cnt == 4'd1) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (!bus.creq.valid) begin
                    state_next = IDLE;
                end else if (last_beat) begin
                    state_next = TURN;
                end
            end
            TURN:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured once at acceptance; later changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt   <= '0;
            beat       <= '0;
            idx        <= '0;
            is_write_q <= 1'b0;
            len_q      <= MLEN1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.creq.valid) begin
                        is_write_q <= bus.creq.is_write;
                        len_q      <= bus.creq.len;
                        idx        <= bus.creq.addr[ADDR_WIDTH+1:2];
                        beat       <= '0;
                        wait_cnt   <= LAT;
                    end
                end
                WAIT: wait_cnt <= wait_cnt - 4'd1;
                BURST: begin
                    if (bus.creq.valid && !last_beat) begin
                        beat <= beat + 4'd1;
                        idx  <= idx + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // A dropped valid or a reset in a write beat suppresses that beat's write.
    always_comb begin
        bus.cresp = '0;
        ram_we    = '0;
        if (state == BURST) begin
            bus.cresp.ready = 1'b1;
            bus.cresp.last  = last_beat;
            if (!is_write_q) begin
                bus.cresp.data = ram_rdata;
            end else if (bus.creq.valid && !reset) begin
                ram_we = bus.creq.strobe;
            end
        end
    end

    cbus_word_ram #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (idx),
        .wdata (bus.creq.data),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_cbus_mem_responder.sv
// Bench for cbus_mem_responder: two instances (10-bit/latency 2, 4-bit/latency 0)
// against an array model of each RAM.
`timescale 1ns/1ps
module tb_cbus_mem_responder;
    import cbus_mem_responder_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cbus_req_t  req_a, req_b;
    cbus_resp_t resp_a, resp_b;

    cbus_mem_responder_if if_a ();
    cbus_mem_responder_if if_b ();

    assign if_a.creq = req_a;
    assign if_b.creq = req_b;
    assign resp_a    = if_a.cresp;
    assign resp_b    = if_b.cresp;

    cbus_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
    cbus_mem_responder #(.ADDR_WIDTH(4),  .LATENCY(0)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] model_a [1024];
    logic [31:0] model_b [16];

    logic [31:0] bdata [16];
    logic [3:0]  bstrb [16];

    int          obs_lat;
    int          obs_beats;
    logic        obs_last [16];
    logic [31:0] obs_data [16];
    logic        obs_turn_ready;
    logic        obs_turn_last;

    function automatic int unsigned widx(input int sel, input logic [31:0] addr, input int unsigned k);
        int unsigned w;
        w = 32'(addr[31:2]) + k;
        return (sel == 0) ? (w % 1024) : (w % 16);
    endfunction

    function automatic logic [31:0] model_get(input int sel, input int unsigned i);
        return (sel == 0) ? model_a[i] : model_b[i];
    endfunction

    function automatic void model_write(input int sel, input int unsigned i, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (sel == 0) model_a[i] = (model_a[i] & ~mask) | (d & mask);
        else          model_b[i] = (model_b[i] & ~mask) | (d & mask);
    endfunction

    function automatic mlen_t pick_len();
        case ($urandom_range(0, 4))
            0:       return MLEN1;
            1:       return MLEN2;
            2:       return MLEN4;
            3:       return MLEN8;
            default: return MLEN16;
        endcase
    endfunction

    function automatic cbus_req_t make_req(input bit wr, input logic [31:0] addr, input mlen_t len);
        cbus_req_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.is_write = wr;
        r.size     = MSIZE4;
        r.addr     = addr;
        r.len      = len;
        r.data     = bdata[0];
        r.strobe   = bstrb[0];
        return r;
    endfunction

    task automatic drive(input int sel, input cbus_req_t r);
        if (sel == 0) req_a = r;
        else          req_b = r;
    endtask

    // Runs one complete burst, recording latency, beats, last flags, read data
    // and the response during the cycle after the last beat (valid still held).
    task automatic xfer(input int sel, input bit wr, input logic [31:0] addr, input mlen_t len);
        cbus_req_t  r;
        cbus_resp_t rs;
        int         cyc;
        r         = make_req(wr, addr, len);
        obs_lat   = -1;
        obs_beats = 0;
        @(negedge clk);
        drive(sel, r);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            rs = (sel == 0) ? resp_a : resp_b;
            if (rs.ready) begin
                if (obs_beats == 0) obs_lat = cyc;
                obs_last[obs_beats] = rs.last;
                obs_data[obs_beats] = rs.data;
                r.data     = bdata[obs_beats];
                r.strobe   = bstrb[obs_beats];
                r.addr     = $urandom;
                r.len      = pick_len();
                r.is_write = 1'($urandom);
                drive(sel, r);
                obs_beats++;
                if (rs.last || obs_beats == 16) break;
            end else if (obs_beats > 0 || cyc > 40) begin
                break;
            end
        end
        @(negedge clk);
        rs             = (sel == 0) ? resp_a : resp_b;
        obs_turn_ready = rs.ready;
        obs_turn_last  = rs.last;
        r.valid        = 1'b0;
        drive(sel, r);
        if (wr) begin
            for (int unsigned k = 0; k <= 32'(len); k++) model_write(sel, widx(sel, addr, k), bdata[k], bstrb[k]);
        end
    endtask

    task automatic test_reset;
        cbus_req_t r;
        reset = 1'b1;
        req_a = '0;
        req_b = '0;
        repeat (2) @(negedge clk);
        n_checks++; if (resp_a !== '0) $display("FAIL reset_resp_a: got %h expected 0", resp_a); else n_pass++;
        n_checks++; if (resp_b !== '0) $display("FAIL reset_resp_b: got %h expected 0", resp_b); else n_pass++;
        bdata[0] = 32'h0; bstrb[0] = 4'h0;
        r = make_req(1'b0, 32'h0, MLEN1);
        req_a = r;
        req_b = r;
        repeat (3) @(negedge clk);
        n_checks++; if (resp_a.ready !== 1'b0) $display("FAIL reset_hold_ready_a: got %b expected 0", resp_a.ready); else n_pass++;
        n_checks++; if (resp_b.ready !== 1'b0) $display("FAIL reset_hold_ready_b: got %b expected 0", resp_b.ready); else n_pass++;
        req_a = '0;
        req_b = '0;
        reset = 1'b0;
    endtask

    task automatic test_fill;
        for (int unsigned k = 0; k < 16; k++) bstrb[k] = 4'hF;
        for (int unsigned blk = 0; blk < 64; blk++) begin
            for (int unsigned k = 0; k < 16; k++) bdata[k] = $urandom;
            xfer(0, 1'b1, 32'(blk * 64), MLEN16);
            n_checks++; if (obs_beats !== 16) $display("FAIL fill_a_beats: got %0d expected 16", obs_beats); else n_pass++;
        end
        for (int unsigned k = 0; k < 16; k++) bdata[k] = $urandom;
        xfer(1, 1'b1, 32'h0, MLEN16);
        n_checks++; if (obs_beats !== 16) $display("FAIL fill_b_beats: got %0d expected 16", obs_beats); else n_pass++;
        n_checks++; if (obs_lat !== 1) $display("FAIL fill_b_latency: got %0d expected 1", obs_lat); else n_pass++;
    endtask

    task automatic test_single_read;
        bdata[0] = 32'hDEADBEEF; bstrb[0] = 4'hF;
        xfer(0, 1'b1, 32'h14, MLEN1);
        bdata[0] = 32'h0;
        xfer(0, 1'b0, 32'h14, MLEN1);
        n_checks++; if (obs_lat !== 3) $display("FAIL single_read_latency: got %0d expected 3", obs_lat); else n_pass++;
        n_checks++; if (obs_beats !== 1) $display("FAIL single_read_beats: got %0d expected 1", obs_beats); else n_pass++;
        n_checks++; if (obs_last[0] !== 1'b1) $display("FAIL single_read_last: got %b expected 1", obs_last[0]); else n_pass++;
        n_checks++; if (obs_data[0] !== 32'hDEADBEEF) $display("FAIL single_read_data: got %h expected deadbeef", obs_data[0]); else n_pass++;
        n_checks++; if (obs_turn_ready !== 1'b0) $display("FAIL single_read_turn_ready: got %b expected 0", obs_turn_ready); else n_pass++;
        n_checks++; if (obs_turn_last !== 1'b0) $display("FAIL single_read_turn_last: got %b expected 0", obs_turn_last); else n_pass++;
    endtask

    task automatic test_burst_write_read;
        logic [31:0] exp4 [4];
        exp4 = '{32'h11, 32'h22, 32'h33, 32'h44};
        for (int k = 0; k < 4; k++) begin bdata[k] = exp4[k]; bstrb[k] = 4'hF; end
        xfer(0, 1'b1, 32'h100, MLEN4);
        n_checks++; if (obs_beats !== 4) $display("FAIL burst_write_beats: got %0d expected 4", obs_beats); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_last[k] !== (k == 3)) $display("FAIL burst_write_last[%0d]: got %b expected %b", k, obs_last[k], (k == 3));
            else n_pass++;
        end
        xfer(0, 1'b0, 32'h100, MLEN4);
        n_checks++; if (obs_lat !== 3) $display("FAIL burst_read_latency: got %0d expected 3", obs_lat); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_data[k] !== exp4[k]) $display("FAIL burst_read_data[%0d]: got %h expected %h", k, obs_data[k], exp4[k]);
            else n_pass++;
        end
    endtask

    task automatic test_partial_strobe;
        bdata[0] = 32'hAABBCCDD; bstrb[0] = 4'hF;
        xfer(0, 1'b1, 32'h0, MLEN1);
        bdata[0] = 32'h11223344; bstrb[0] = 4'b0101;
        xfer(0, 1'b1, 32'h0, MLEN1);
        xfer(0, 1'b0, 32'h0, MLEN1);
        n_checks++; if (obs_data[0] !== 32'hAA22CC44) $display("FAIL partial_strobe_data: got %h expected aa22cc44", obs_data[0]); else n_pass++;
    endtask

    task automatic test_wrap;
        for (int k = 0; k < 4; k++) begin bdata[k] = 32'(k + 1); bstrb[k] = 4'hF; end
        xfer(1, 1'b1, 32'(14 * 4), MLEN4);
        n_checks++; if (obs_last[3] !== 1'b1) $display("FAIL wrap_write_last: got %b expected 1", obs_last[3]); else n_pass++;
        xfer(1, 1'b0, 32'h0, MLEN16);
        n_checks++; if (obs_data[14] !== 32'd1) $display("FAIL wrap_word14: got %h expected 1", obs_data[14]); else n_pass++;
        n_checks++; if (obs_data[15] !== 32'd2) $display("FAIL wrap_word15: got %h expected 2", obs_data[15]); else n_pass++;
        n_checks++; if (obs_data[0]  !== 32'd3) $display("FAIL wrap_word0: got %h expected 3", obs_data[0]); else n_pass++;
        n_checks++; if (obs_data[1]  !== 32'd4) $display("FAIL wrap_word1: got %h expected 4", obs_data[1]); else n_pass++;
    endtask

    task automatic test_back_to_back;
        cbus_req_t   r;
        logic [6:0]  rdy, lst, exp_rdy, exp_lst;
        logic [31:0] dat [7];
        exp_rdy = 7'b0110011;
        exp_lst = 7'b0100010;
        r = make_req(1'b0, 32'h8, MLEN2);
        @(negedge clk);
        req_b = r;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            rdy[c] = resp_b.ready;
            lst[c] = resp_b.last;
            dat[c] = resp_b.data;
            if (c == 2) begin r.addr = 32'h34; req_b = r; end
            if (c == 6) begin r.valid = 1'b0; req_b = r; end
        end
        n_checks++; if (rdy !== exp_rdy) $display("FAIL b2b_ready_pattern: got %b expected %b", rdy, exp_rdy); else n_pass++;
        n_checks++; if (lst !== exp_lst) $display("FAIL b2b_last_pattern: got %b expected %b", lst, exp_lst); else n_pass++;
        n_checks++; if (dat[0] !== model_b[2])  $display("FAIL b2b_data0: got %h expected %h", dat[0], model_b[2]); else n_pass++;
        n_checks++; if (dat[1] !== model_b[3])  $display("FAIL b2b_data1: got %h expected %h", dat[1], model_b[3]); else n_pass++;
        n_checks++; if (dat[4] !== model_b[13]) $display("FAIL b2b_data2: got %h expected %h", dat[4], model_b[13]); else n_pass++;
        n_checks++; if (dat[5] !== model_b[14]) $display("FAIL b2b_data3: got %h expected %h", dat[5], model_b[14]); else n_pass++;
    endtask

    task automatic test_abort;
        cbus_req_t r;
        int        beats, cyc;
        for (int k = 0; k < 16; k++) begin bdata[k] = $urandom; bstrb[k] = 4'hF; end
        r = make_req(1'b1, 32'(200 * 4), MLEN8);
        @(negedge clk);
        req_a = r;
        beats = 0;
        cyc   = 0;
        while (beats < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (resp_a.ready) begin r.data = bdata[beats]; req_a = r; beats++; end
        end
        n_checks++; if (beats !== 3) $display("FAIL abort_reach_beats: got %0d expected 3", beats); else n_pass++;
        @(negedge clk);
        r.valid = 1'b0;
        r.data  = bdata[3];
        req_a   = r;
        @(negedge clk);
        n_checks++; if (resp_a.ready !== 1'b0) $display("FAIL abort_idle_ready: got %b expected 0", resp_a.ready); else n_pass++;
        for (int unsigned k = 0; k < 3; k++) model_write(0, 200 + k, bdata[k], 4'hF);
        xfer(0, 1'b0, 32'(200 * 4), MLEN8);
        for (int unsigned k = 0; k < 8; k++) begin
            n_checks++;
            if (obs_data[k] !== model_a[200 + k]) $display("FAIL abort_readback[%0d]: got %h expected %h", k, obs_data[k], model_a[200 + k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_burst;
        cbus_req_t r;
        int        beats, cyc;
        r = make_req(1'b0, 32'(300 * 4), MLEN8);
        @(negedge clk);
        req_a = r;
        beats = 0;
        cyc   = 0;
        while (beats < 2 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (resp_a.ready) beats++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (resp_a.ready !== 1'b0) $display("FAIL rst_mid_read_ready: got %b expected 0", resp_a.ready); else n_pass++;
        n_checks++; if (resp_a.last !== 1'b0) $display("FAIL rst_mid_read_last: got %b expected 0", resp_a.last); else n_pass++;
        reset = 1'b0;
        r.valid = 1'b0;
        req_a = r;
        xfer(0, 1'b0, 32'(300 * 4), MLEN8);
        n_checks++; if (obs_lat !== 3) $display("FAIL rst_after_latency: got %0d expected 3", obs_lat); else n_pass++;
        for (int unsigned k = 0; k < 8; k++) begin
            n_checks++;
            if (obs_data[k] !== model_a[300 + k]) $display("FAIL rst_after_data[%0d]: got %h expected %h", k, obs_data[k], model_a[300 + k]);
            else n_pass++;
        end
        for (int k = 0; k < 4; k++) begin bdata[k] = $urandom; bstrb[k] = 4'hF; end
        r = make_req(1'b1, 32'(400 * 4), MLEN4);
        @(negedge clk);
        req_a = r;
        beats = 0;
        cyc   = 0;
        while (beats < 1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (resp_a.ready) begin r.data = bdata[beats]; req_a = r; beats++; end
        end
        @(negedge clk);
        r.data = bdata[1];
        req_a  = r;
        reset  = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        r.valid = 1'b0;
        req_a   = r;
        model_write(0, 400, bdata[0], 4'hF);
        xfer(0, 1'b0, 32'(400 * 4), MLEN4);
        for (int unsigned k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_data[k] !== model_a[400 + k]) $display("FAIL rst_mid_write[%0d]: got %h expected %h", k, obs_data[k], model_a[400 + k]);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        int          sel, exp_lat;
        bit          wr;
        mlen_t       len;
        logic [31:0] addr;
        int unsigned nb;
        for (int n = 0; n < 40; n++) begin
            sel     = $urandom_range(0, 1);
            wr      = 1'($urandom);
            len     = pick_len();
            addr    = $urandom;
            nb      = 32'(len) + 1;
            exp_lat = (sel == 0) ? 3 : 1;
            for (int k = 0; k < 16; k++) begin bdata[k] = $urandom; bstrb[k] = 4'($urandom); end
            xfer(sel, wr, addr, len);
            n_checks++; if (obs_lat !== exp_lat) $display("FAIL rand_latency op%0d: got %0d expected %0d", n, obs_lat, exp_lat); else n_pass++;
            n_checks++; if (obs_beats !== int'(nb)) $display("FAIL rand_beats op%0d: got %0d expected %0d", n, obs_beats, nb); else n_pass++;
            n_checks++; if (obs_turn_ready !== 1'b0) $display("FAIL rand_turn_ready op%0d: got %b expected 0", n, obs_turn_ready); else n_pass++;
            for (int unsigned k = 0; k < nb; k++) begin
                n_checks++;
                if (obs_last[k] !== (k == nb - 1)) $display("FAIL rand_last op%0d beat%0d: got %b expected %b", n, k, obs_last[k], (k == nb - 1));
                else n_pass++;
                if (!wr) begin
                    n_checks++;
                    if (obs_data[k] !== model_get(sel, widx(sel, addr, k)))
                        $display("FAIL rand_read op%0d beat%0d: got %h expected %h", n, k, obs_data[k], model_get(sel, widx(sel, addr, k)));
                    else n_pass++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_single_read();
        test_burst_write_read();
        test_partial_strobe();
        test_wrap();
        test_back_to_back();
        test_abort();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/cbus_mem_responder.md
Name: cbus_mem_responder

Overview:
- Responder end of the cached bus (CBus): accepts `cbus_req_t` bursts from an initiator (e.g. the CBus arbiter output `oreq`) and answers with `cbus_resp_t` beats.
- Backed by an internal word-organised RAM with a programmable first-beat latency.
- Used as the memory model behind the core/arbiter in simulation and as the on-chip scratch RAM target.

Parameters:
- ADDR_WIDTH, 10: RAM depth is 2^ADDR_WIDTH 32-bit words.
- LATENCY, 2: wait cycles between request acceptance and the first data beat (0..15).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- creq  in  cbus_req_t  request from initiator: valid, is_write, size, addr, strobe, data, len.
- cresp  out  cbus_resp_t  response to initiator: ready, last, data.

Behaviour:
- States: IDLE, WAIT, BURST, TURN.
- Reset: state=IDLE; cresp.ready=0, cresp.last=0, cresp.data=0. RAM contents are not cleared by reset.
- IDLE, creq.valid=1 at cycle t: latch is_write, len, word index = addr[ADDR_WIDTH+1:2] and beat counter=0.
  - Go to WAIT with counter=LATENCY; if LATENCY=0, go straight to BURST.
  - First beat is at cycle t+1+LATENCY.
- WAIT: decrement counter each cycle; go to BURST when it would reach 0.
- BURST: cresp.ready=1 every cycle, one beat per cycle.
  - Beats = len+1 (MLEN1=1, MLEN2=2, MLEN4=4, MLEN8=8, MLEN16=16).
  - cresp.last=1 on the beat where beat counter == len.
  - After each beat, index increments by 1, wrapping modulo 2^ADDR_WIDTH.
- Read beat: cresp.data = RAM[index]. Always a full word; size and strobe are ignored for reads.
- Write beat: RAM[index] byte i <= creq.data byte i where creq.strobe[i]=1, committed at the clock edge of the ready cycle. Byte lanes with strobe 0 are untouched; size is informational only.
- After the last beat: go to TURN. TURN lasts one cycle, ignores creq.valid and has ready=0, so the held request is not re-accepted. TURN then goes to IDLE.
- cresp.data outside read BURST cycles: 0.
- Timing paths: cresp is a function of registered state and RAM only. There is no combinational path from creq to cresp.
- creq.valid low during WAIT or BURST is a protocol abort: return to IDLE next cycle and perform no write in that cycle. Beats already written remain written.
- Request fields other than data and strobe are sampled only in IDLE. Later changes mid-burst are ignored.
- Reset asserted mid-burst: IDLE next cycle, outputs 0, the in-flight write beat in that cycle is not performed.
- Address bits above ADDR_WIDTH+1 and bits [1:0] are ignored (aliasing is by design).

Decomposition:
- `cbus_req_t`, `cbus_resp_t`, `mlen_t` and `strobe_t` stay in the shared common package.
- Add `CBUS_MEM_DEFAULT_LATENCY` to that package.
- Local state enum lives inside the module.
- One sub-module, `cbus_word_ram`: single-port 32-bit RAM with 4-bit byte write-enable and asynchronous read. The responder FSM owns all protocol logic.

Test Plan:
- Reset then single read:
  - Stimulus: preload word 5 = 0xDEADBEEF; valid=1, is_write=0, addr=0x14, len=MLEN1, LATENCY=2.
  - Expected: ready=1 and last=1 exactly 3 cycles after acceptance, data=0xDEADBEEF, one TURN cycle with ready=0 while valid is still held.
- Burst write then burst read:
  - Stimulus: write MLEN4 at addr 0x100 with data 0x11,0x22,0x33,0x44 and strobe 0xF, then read MLEN4 at 0x100.
  - Expected: 4 consecutive ready beats, last on the 4th, read data 0x11,0x22,0x33,0x44.
- Partial strobe:
  - Stimulus: word 0 = 0xAABBCCDD; write data 0x11223344 with strobe 4'b0101.
  - Expected: subsequent read returns 0xAA22CC44.
- Wrap-around:
  - Stimulus: ADDR_WIDTH=4; MLEN4 write at word 14 with values 1,2,3,4.
  - Expected: words 14,15,0,1 hold 1,2,3,4.
- LATENCY=0 back-to-back:
  - Stimulus: two MLEN2 reads issued immediately after each other.
  - Expected: first beat 1 cycle after acceptance; second request accepted only after the TURN cycle.
- Abort and reset mid-burst:
  - MLEN8 write: drop valid after beat 3. Expected: only 3 words written, block in IDLE next cycle.
  - MLEN8 read: assert reset during beat 2. Expected: ready=0 and last=0 next cycle, next request served normally.
